// File: rtl/mc_payoff_acc.sv
// Monte-Carlo payoff accumulator: averages call/put payoffs over 2^NPATH_LOG paths per day, NDAY days per run.
// Optional running-max output enabled by defining MC_MAXPAY_EN.
module mc_payoff_acc #(
  parameter int DW        = 12,
  parameter int NPATH_LOG = 8,
  parameter int NDAY      = 8,
  localparam int DAYW     = (NDAY > 1) ? $clog2(NDAY) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_put,
  input  logic [DW-1:0]   K,
  input  logic            path_valid,
  input  logic [DW-1:0]   path,
  output logic            path_ready,
  output logic            price_valid,
  output logic [DW-1:0]   price,
  output logic [DAYW-1:0] day,
  output logic            done
`ifdef MC_MAXPAY_EN
  ,
  output logic [DW-1:0]   max_pay
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting path samples for the current day
  // OUT   | day result presented (price_valid high)
  // DONE  | done strobe after the last day
  typedef enum logic [1:0] {IDLE, RUN, OUT, DONE} state_t;

  localparam int AW = DW + NPATH_LOG;
  localparam int CW = (NPATH_LOG > 0) ? NPATH_LOG : 1;
  localparam logic [CW-1:0]   CNT_LAST = (NPATH_LOG > 0) ? {CW{1'b1}} : '0;
  localparam logic [DAYW-1:0] DAY_LAST = DAYW'(NDAY - 1);

  state_t          state;
  logic [DW-1:0]   k_q;
  logic            put_q;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [DAYW-1:0] day_cnt;
  logic [DW-1:0]   payoff;
  logic [AW-1:0]   acc_sum;

  always_comb begin
    payoff = '0;
    if (put_q) begin
      if (k_q > path) payoff = k_q - path;
    end else begin
      if (path > k_q) payoff = path - k_q;
    end
    acc_sum = acc + AW'(payoff);
  end

`ifdef MC_MAXPAY_EN
  logic [DW-1:0] max_run;
  logic [DW-1:0] max_next;
  always_comb begin
    max_next = (payoff > max_run) ? payoff : max_run;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k_q         <= '0;
      put_q       <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      day_cnt     <= '0;
      path_ready  <= 1'b0;
      price_valid <= 1'b0;
      price       <= '0;
      day         <= '0;
      done        <= 1'b0;
`ifdef MC_MAXPAY_EN
      max_run     <= '0;
      max_pay     <= '0;
`endif
    end else begin
      price_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q        <= K;
            put_q      <= is_put;
            acc        <= '0;
            cnt        <= '0;
            day_cnt    <= '0;
`ifdef MC_MAXPAY_EN
            max_run    <= '0;
`endif
            path_ready <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (path_valid && path_ready) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
`ifdef MC_MAXPAY_EN
            max_run <= max_next;
`endif
            // Last sample of the day: result is published on this same edge.
            if (cnt == CNT_LAST) begin
              price       <= acc_sum[AW-1:NPATH_LOG];
              day         <= day_cnt;
              price_valid <= 1'b1;
              path_ready  <= 1'b0;
`ifdef MC_MAXPAY_EN
              max_pay     <= max_next;
`endif
              state       <= OUT;
            end
          end
        end
        OUT: begin
          acc <= '0;
          cnt <= '0;
`ifdef MC_MAXPAY_EN
          max_run <= '0;
`endif
          if (day_cnt == DAY_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            day_cnt    <= day_cnt + 1'b1;
            path_ready <= 1'b1;
            state      <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          path_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_payoff_acc.md
MC_PAYOFF_ACC -- requirements
Module: mc_payoff_acc

Interface
REQ-001 SHALL have parameter DW, default 12, the width of path, K and price (unsigned fixed point).
REQ-002 SHALL have parameter NPATH_LOG, default 8: paths per day = 2^NPATH_LOG.
REQ-003 SHALL have parameter NDAY, default 8, the number of days per run (at least 1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle run request.
REQ-007 SHALL have port is_put, input, 1, payoff select (0 = call, 1 = put), sampled on start.
REQ-008 SHALL have port K, input, DW, strike, sampled on start.
REQ-009 SHALL have port path_valid, input, 1, path sample present.
REQ-010 SHALL have port path, input, DW, terminal price of one simulated path.
REQ-011 SHALL have port path_ready, output, 1, block accepts a sample this cycle.
REQ-012 SHALL have port price_valid, output, 1, one-cycle strobe for a day result.
REQ-013 SHALL have port price, output, DW, average payoff for the day.
REQ-014 SHALL have port day, output, clog2(NDAY) bits (minimum 1), index of the reported day.
REQ-015 SHALL have port done, output, 1, one-cycle strobe after the last day.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, OUT and DONE.
REQ-017 SHALL, in IDLE with start=1, latch K and is_put, clear the accumulator, sample count and day, and go to RUN next cycle; start in any other state is ignored.
REQ-018 SHALL drive path_ready=1 only in RUN; a sample is accepted on an edge where path_valid and path_ready are both 1; valid gaps are allowed and do not change the count.
REQ-019 SHALL compute the payoff combinationally as: call = max(path−K, 0); put = max(K−path, 0); result is DW bits, unsigned.
REQ-020 SHALL use an accumulator of DW+NPATH_LOG bits so that overflow cannot occur; on each accepted sample, acc <= acc + payoff and count increments.
REQ-021 SHALL, when the sample accepted is number 2^NPATH_LOG−1 (counting from 0), move to OUT on that same edge.
REQ-022 SHALL, in OUT, hold price_valid=1 for exactly one cycle with price = acc[DW+NPATH_LOG−1:NPATH_LOG] (truncating divide) and day = current day index.
REQ-023 SHALL, on leaving OUT, clear acc and count; if day = NDAY−1 go to DONE, otherwise increment day and return to RUN.
REQ-024 SHALL, in DONE, assert done=1 for one cycle, then go to IDLE.
REQ-025 SHALL give a latency of one cycle: price_valid is high in the cycle immediately after the accepting edge of the last sample; day results are back-to-back apart from the single OUT cycle.
REQ-026 SHALL hold price and day at their last reported values outside OUT.
REQ-027 SHALL handle boundaries as follows: path = K gives payoff 0; K = 0 with call gives payoff = path; NPATH_LOG = 0 reports each sample directly.

Reset
REQ-028 SHALL, with reset=1 at any edge, including mid-day, force state to IDLE and clear acc, count, day, price, latched K and latched is_put.
REQ-029 SHALL drive path_ready=0, price_valid=0, price=0, day=0 and done=0 while in reset.
REQ-030 SHALL give reset priority over start and over path acceptance in the same cycle.

Configuration
REQ-031 SHALL, when macro MC_MAXPAY_EN is defined, add output max_pay (DW bits): the running maximum payoff of the current day, valid alongside price in OUT, cleared with acc and on reset.
REQ-032 SHALL, when MC_MAXPAY_EN is undefined, have no max_pay port and no related logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover a call run: K=0x300, call, 256 samples of 0x400 per day, NDAY=8 -> eight price_valid strobes, each price=0x100, day=0..7, then done once.
REQ-034 SHALL cover put with strike above and below: K=0x300, put, all samples 0x400 -> price=0x000; all samples 0x200 -> price=0x100.
REQ-035 SHALL cover mixed samples with backpressure: K=0x300, call, 128×0x500 plus 128×0x100, with path_valid toggled randomly -> price=0x100, and the count is unaffected by the gaps.
REQ-036 SHALL cover full scale: K=0, call, 256×0xFFF -> price=0xFFF with no overflow; with MC_MAXPAY_EN, max_pay=0xFFF.
REQ-037 SHALL cover reset mid-day: reset after 100 samples on day 3, then a new start -> no price_valid until 256 new samples are accepted, and day restarts at 0.
REQ-038 SHALL cover start ignored while running: start pulsed in RUN with K=0x000 -> results still use the originally latched K=0x300.
